// File: rtl/home_zone_if.sv
// Sensor/actuator bundle between the sensor front end and the zone controller.
// The master drives sensor levels and the tick strobe; the slave drives actuators.
interface home_zone_if #(
  parameter int NZONES = 4
) ();
  logic              tick;
  logic [NZONES-1:0] pir;
  logic              isDark;
  logic              tempHigh;
  logic              authorized;
  logic              arm;
  logic [NZONES-1:0] lightOn;
  logic              fanOn;
  logic              alarmOn;
  logic              armed;
  logic [1:0]        sec_state;

  modport master (
    output tick, pir, isDark, tempHigh, authorized, arm,
    input  lightOn, fanOn, alarmOn, armed, sec_state
  );

  modport slave (
    input  tick, pir, isDark, tempHigh, authorized, arm,
    output lightOn, fanOn, alarmOn, armed, sec_state
  );
endinterface

// File: rtl/home_zone_controller.sv
// Multi-zone home controller: PIR-held zone lights, dwell-limited fan and an
// arm/entry/alarm security FSM, all timed in tick strobes.
module home_zone_controller #(
  parameter int NZONES      = 4,
  parameter int LIGHT_HOLD  = 60,
  parameter int FAN_MIN     = 20,
  parameter int ENTRY_DELAY = 30,
  parameter int ALARM_TIME  = 120
) (
  input  logic clk,
  input  logic rst,
  home_zone_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(LIGHT_HOLD, FAN_MIN), max2(ENTRY_DELAY, ALARM_TIME));
  localparam int TW   = $clog2(MAXP + 1);

  typedef logic [TW-1:0] tmr_t;

  localparam tmr_t ONE     = tmr_t'(1);
  localparam tmr_t T_LIGHT = tmr_t'(LIGHT_HOLD);
  localparam tmr_t T_FAN   = tmr_t'(FAN_MIN);
  localparam tmr_t T_ENTRY = tmr_t'(ENTRY_DELAY);
  localparam tmr_t T_ALARM = tmr_t'(ALARM_TIME);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    ENTRY    = 2'd2,
    ALARM    = 2'd3
  } sec_t;

  logic [NZONES-1:0] light_vec;

  // Each zone owns its own hold timer; fresh dark-room motion re-arms it every cycle.
  for (genvar gi = 0; gi < NZONES; gi++) begin : g_zone
    tmr_t hold_q, hold_d;
    logic light_q, light_d;

    always_comb begin
      hold_d  = hold_q;
      light_d = light_q;
      if (!bus.isDark) begin
        hold_d  = '0;
        light_d = 1'b0;
      end else if (bus.pir[gi]) begin
        hold_d  = T_LIGHT;
        light_d = 1'b1;
      end else if (bus.tick && hold_q != '0) begin
        hold_d = hold_q - ONE;
        if (hold_q == ONE) light_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_q  <= '0;
        light_q <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        light_q <= light_d;
      end
    end

    assign light_vec[gi] = light_q;
  end

  tmr_t fcnt_q, fcnt_d;
  logic fan_q, fan_d;

  // Fan may only toggle once its dwell timer has run out, filtering a chattering tempHigh.
  always_comb begin
    fan_d  = fan_q;
    fcnt_d = fcnt_q;
    if (bus.tick && fcnt_q != '0) fcnt_d = fcnt_q - ONE;
    if (fcnt_q == '0) begin
      if (!fan_q && bus.tempHigh) begin
        fan_d  = 1'b1;
        fcnt_d = T_FAN;
      end else if (fan_q && !bus.tempHigh) begin
        fan_d  = 1'b0;
        fcnt_d = T_FAN;
      end
    end
  end

  sec_t state_q, state_d;
  tmr_t scnt_q, scnt_d;
  logic alarm_q, alarm_d;
  logic armed_q, armed_d;
  logic s_expire;

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    s_expire = bus.tick && (scnt_q == ONE);
    if (bus.tick && scnt_q != '0) scnt_d = scnt_q - ONE;
    unique case (state_q)
      DISARMED: if (bus.arm && !bus.authorized) state_d = ARMED;
      ARMED: begin
        if (bus.authorized) begin
          state_d = DISARMED;
        end else if (|bus.pir) begin
          state_d = ENTRY;
          scnt_d  = T_ENTRY;
        end
      end
      ENTRY: begin
        if (bus.authorized) begin
          state_d = DISARMED;
          scnt_d  = '0;
        end else if (s_expire) begin
          state_d = ALARM;
          scnt_d  = T_ALARM;
        end
      end
      ALARM: begin
        if (bus.authorized) begin
          state_d = DISARMED;
          scnt_d  = '0;
        end else if (s_expire) begin
          state_d = ARMED;
        end
      end
      default: state_d = DISARMED;
    endcase
    // Output flops follow the next state so they change on the same edge as sec_state.
    alarm_d = (state_d == ALARM);
    armed_d = (state_d != DISARMED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fan_q   <= 1'b0;
      fcnt_q  <= '0;
      state_q <= DISARMED;
      scnt_q  <= '0;
      alarm_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      fan_q   <= fan_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      scnt_q  <= scnt_d;
      alarm_q <= alarm_d;
      armed_q <= armed_d;
    end
  end

  assign bus.lightOn   = light_vec;
  assign bus.fanOn     = fan_q;
  assign bus.alarmOn   = alarm_q;
  assign bus.armed     = armed_q;
  assign bus.sec_state = state_q;

endmodule

// File: tb/tb_home_zone_controller.sv
// Directed scoreboard bench for home_zone_controller: stimulus queues expected
// outputs, a negedge monitor pops and compares them.
module tb_home_zone_controller;
  localparam int NZ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  longint cyc = 0;

  home_zone_if #(.NZONES(NZ)) bus ();

  home_zone_controller #(.NZONES(NZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] val;
    longint     due;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] actual(input int sel);
    case (sel)
      0:       return {4'b0, bus.lightOn};
      1:       return {7'b0, bus.fanOn};
      2:       return {7'b0, bus.alarmOn};
      3:       return {7'b0, bus.armed};
      default: return {6'b0, bus.sec_state};
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle, away from posedge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      logic [7:0] a;
      e = sb.pop_front();
      a = actual(e.sel);
      total++;
      if (a !== e.val) begin
        bad++;
        $display("FAIL %s (sel %0d): got %0h expected %0h", e.name, e.sel, a, e.val);
      end else begin
        $display("ok   %s (sel %0d) = %0h", e.name, e.sel, a);
      end
    end
  end

  task automatic chk_push(input string name, input int sel, input logic [7:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = v;
    e.due  = cyc;
    sb.push_back(e);
  endtask

  task automatic chk_all(input string name, input logic [3:0] l, input logic f,
                         input logic al, input logic ar, input logic [1:0] st);
    chk_push(name, 0, {4'b0, l});
    chk_push(name, 1, {7'b0, f});
    chk_push(name, 2, {7'b0, al});
    chk_push(name, 3, {7'b0, ar});
    chk_push(name, 4, {6'b0, st});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic one_tick();
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      one_tick();
      step(3);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    bus.tick = 0; bus.pir = '0; bus.isDark = 0; bus.tempHigh = 0;
    bus.authorized = 0; bus.arm = 0;

    step(2);
    chk_all("reset", 4'h0, 0, 0, 0, 2'd0);
    rst = 1'b0;
    step(1);

    // Zone light hold and expiry on the 60th tick
    bus.isDark = 1;
    bus.pir = 4'b0001;
    chk_push("light_not_yet", 0, 8'h00);
    step(1);
    bus.pir = '0;
    chk_push("light0_on", 0, 8'h01);
    ticks(59);
    chk_push("light0_tick59", 0, 8'h01);
    one_tick();
    chk_push("light0_tick60_off", 0, 8'h00);
    step(3);

    // Re-trigger mid-hold, then darkness lost
    bus.pir = 4'b0010;
    step(1);
    bus.pir = '0;
    chk_push("light1_on", 0, 8'h02);
    ticks(50);
    bus.pir = 4'b0010;
    step(1);
    bus.pir = '0;
    ticks(30);
    chk_push("light1_retrig30", 0, 8'h02);
    ticks(29);
    chk_push("light1_retrig59", 0, 8'h02);
    bus.isDark = 0;
    step(1);
    chk_push("light1_dark_off", 0, 8'h00);

    // Fan: on one clk after reset with tempHigh steady, then chattering tempHigh
    rst = 1'b1;
    bus.tempHigh = 1;
    step(2);
    rst = 1'b0;
    chk_push("fan_after_rst", 1, 8'h00);
    step(1);
    chk_push("fan_on_1clk", 1, 8'h01);
    for (int k = 1; k <= 64; k++) begin
      logic fexp;
      bus.tempHigh = (((k - 1) / 3) % 2) == 1;
      one_tick();
      fexp = (k <= 20) ? 1'b1 : (k <= 40) ? 1'b0 : (k <= 60) ? 1'b1 : 1'b0;
      chk_push($sformatf("fan_chatter_k%0d", k), 1, {7'b0, fexp});
      step(3);
    end

    // Security: arm, entry, alarm, auto re-arm
    bus.tempHigh = 0;
    do_reset();
    bus.arm = 1;
    step(1);
    bus.arm = 0;
    chk_all("sec_armed", 4'h0, 0, 0, 1, 2'd1);
    bus.pir = 4'b0100;
    step(1);
    bus.pir = '0;
    chk_all("sec_entry", 4'h0, 0, 0, 1, 2'd2);
    ticks(29);
    chk_all("sec_entry_t29", 4'h0, 0, 0, 1, 2'd2);
    one_tick();
    chk_all("sec_alarm", 4'h0, 0, 1, 1, 2'd3);
    step(3);
    ticks(119);
    chk_all("sec_alarm_t119", 4'h0, 0, 1, 1, 2'd3);
    one_tick();
    chk_all("sec_rearm", 4'h0, 0, 0, 1, 2'd1);
    step(3);

    // Authorization on the expiring tick, and arm&authorized
    bus.pir = 4'b0100;
    step(1);
    bus.pir = '0;
    chk_push("sec_entry2", 4, 8'd2);
    ticks(29);
    bus.authorized = 1;
    one_tick();
    chk_all("auth_on_expiry", 4'h0, 0, 0, 0, 2'd0);
    bus.arm = 1;
    step(2);
    chk_all("arm_with_auth", 4'h0, 0, 0, 0, 2'd0);
    bus.authorized = 0;
    step(1);
    bus.arm = 0;
    chk_push("arm_alone", 4, 8'd1);
    bus.authorized = 1;
    step(1);
    bus.authorized = 0;
    chk_push("auth_in_armed", 4, 8'd0);

    // Asynchronous reset during ALARM with light and fan on
    bus.isDark = 1;
    bus.tempHigh = 1;
    do_reset();
    bus.arm = 1;
    step(1);
    bus.arm = 0;
    bus.pir = 4'b1000;
    step(1);
    bus.pir = '0;
    ticks(30);
    chk_all("pre_rst_alarm", 4'h8, 1, 1, 1, 2'd3);
    step(1);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'h0, 0, 0, 0, 2'd0);
    step(2);
    rst = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
